// File: rtl/serial_addsub_word.sv
// Digit-serial adder/subtractor: one W-bit digit per cycle, LSB first.
// Registered outputs, one-cycle latency, word carry and signed overflow on the last digit.
module serial_addsub_word #(
    parameter int W        = 1,
    parameter int N_DIGITS = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_in,
    input  logic         first,
    input  logic         sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         valid_out,
    output logic [W-1:0] sum,
    output logic         last,
    output logic         cout,
    output logic         ovf,
    output logic         err
);

    localparam int CW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N_DIGITS - 1);
    localparam logic ONE_DIGIT = (N_DIGITS == 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          carry;
    logic          sub_q;

    logic          sub_eff;
    logic          c_in;
    logic          c_msb;
    logic          is_last;
    logic [W-1:0]  b_eff;
    logic [W:0]    full;

    // first=1 always restarts the word, even mid-word (abort)
    always_comb begin
        sub_eff = first ? sub : sub_q;
        c_in    = first ? sub : carry;
        b_eff   = sub_eff ? ~b : b;
        full    = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, c_in};
        c_msb   = full[W-1] ^ a[W-1] ^ b_eff[W-1];
        is_last = first ? ONE_DIGIT : (cnt == LAST_CNT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            carry     <= 1'b0;
            sub_q     <= 1'b0;
            valid_out <= 1'b0;
            sum       <= '0;
            last      <= 1'b0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            err       <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            sum       <= '0;
            last      <= 1'b0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            err       <= 1'b0;
            if (valid_in) begin
                if (first || state == RUN) begin
                    valid_out <= 1'b1;
                    sum       <= full[W-1:0];
                    carry     <= full[W];
                    last      <= is_last;
                    if (is_last) begin
                        cout  <= full[W];
                        ovf   <= c_msb ^ full[W];
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt   <= first ? CW'(1) : cnt + CW'(1);
                        state <= RUN;
                    end
                    if (first) begin
                        sub_q <= sub;
                        err   <= (state == RUN);
                    end
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub_word.sv
// Bench for serial_addsub_word (W=4, N_DIGITS=4): word-level arithmetic model
// checked every cycle, plus literal word results for directed vectors.
module tb_serial_addsub_word;

    localparam int W = 4;
    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       valid_in = 1'b0;
    logic       first = 1'b0;
    logic       sub = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       valid_out;
    logic [3:0] sum;
    logic       last;
    logic       cout;
    logic       ovf;
    logic       err;

    serial_addsub_word #(.W(W), .N_DIGITS(N)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .first(first),
        .sub(sub), .a(a), .b(b), .valid_out(valid_out), .sum(sum),
        .last(last), .cout(cout), .ovf(ovf), .err(err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // word-level model state
    bit          m_in = 1'b0;
    int          m_idx = 0;
    logic [15:0] m_a, m_b;
    bit          m_sub;
    logic [16:0] r;
    logic        s_rst, s_v, s_f, s_s;
    logic [3:0]  s_a, s_b;
    logic        e_v, e_last, e_cout, e_ovf, e_err;
    logic [3:0]  e_sum;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
    } wres_t;
    wres_t       wq[$];
    logic [15:0] w_acc = '0;
    int          w_idx = 0;
    int          err_cnt = 0;
    int          val_cnt = 0;
    int          run = 0;
    int          max_run = 0;

    always @(posedge clk) begin
        s_rst = rst; s_v = valid_in; s_f = first; s_s = sub;
        s_a = a; s_b = b;
        e_v = 0; e_sum = 0; e_last = 0; e_cout = 0; e_ovf = 0; e_err = 0;
        if (!s_rst) begin
            m_in = 0;
            m_idx = 0;
        end else if (s_v) begin
            if (s_f) begin
                e_err = m_in;
                m_in = 1; m_idx = 0; m_a = 0; m_b = 0; m_sub = s_s;
            end else if (!m_in) begin
                e_err = 1;
            end
            if (m_in) begin
                m_a[4*m_idx +: 4] = s_a;
                m_b[4*m_idx +: 4] = s_b;
                r = m_sub ? {1'b0, m_a} + {1'b0, ~m_b} + 17'd1
                          : {1'b0, m_a} + {1'b0, m_b};
                e_v = 1;
                e_sum = r[4*m_idx +: 4];
                if (m_idx == N - 1) begin
                    e_last = 1;
                    e_cout = r[16];
                    e_ovf = m_sub
                        ? (m_a[15] != m_b[15] && r[15] != m_a[15])
                        : (m_a[15] == m_b[15] && r[15] != m_a[15]);
                    m_in = 0;
                end
                m_idx++;
            end
        end
        #1;
        chk("valid_out", valid_out, e_v);
        chk("sum", sum, e_sum);
        chk("last", last, e_last);
        chk("cout", cout, e_cout);
        chk("ovf", ovf, e_ovf);
        chk("err", err, e_err);
        if (!rst) w_idx = 0;
        if (err) begin
            err_cnt++;
            w_idx = 0;
        end
        if (valid_out) begin
            val_cnt++;
            run++;
            if (w_idx < N) w_acc[4*w_idx +: 4] = sum;
            w_idx++;
            if (last) begin
                wq.push_back('{w_acc, cout, ovf});
                w_idx = 0;
            end
        end else begin
            run = 0;
        end
        if (run > max_run) max_run = run;
    end

    task automatic cyc(input bit v, input bit f, input bit s,
                       input logic [3:0] da, input logic [3:0] db);
        @(negedge clk);
        valid_in = v; first = f; sub = s; a = da; b = db;
    endtask

    // idle cycles carry junk on the data inputs to prove they are ignored
    task automatic idle(input int n);
        repeat (n) cyc(0, 1, 1, 4'hF, 4'hA);
    endtask

    task automatic send_word(input logic [15:0] wa, input logic [15:0] wb,
                             input bit s, input int gap, input int ndig);
        for (int i = 0; i < ndig; i++) begin
            cyc(1, i == 0, (i == 0) ? s : !s, wa[4*i +: 4], wb[4*i +: 4]);
            if (i < ndig - 1) idle(gap);
        end
    endtask

    task automatic expect_word(input string nm, input logic [15:0] es,
                               input logic ec, input logic eo);
        wres_t w;
        if (wq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: got no word expected %0h", nm, es);
        end else begin
            w = wq.pop_front();
            chk({nm, "_sum"}, w.s, es);
            chk({nm, "_cout"}, w.c, ec);
            chk({nm, "_ovf"}, w.o, eo);
        end
    endtask

    int e0;
    int v0;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid", valid_out, 0);
        chk("rst_sum", sum, 0);
        chk("rst_err", err, 0);
        chk("rst_last", last, 0);
        rst = 1'b1;
        idle(1);

        send_word(16'h1234, 16'h0FFF, 0, 0, 4); idle(2);
        expect_word("add", 16'h2233, 0, 0);
        send_word(16'h0003, 16'h0005, 1, 0, 4); idle(2);
        expect_word("sub_borrow", 16'hFFFE, 0, 0);
        send_word(16'h8000, 16'h0001, 1, 0, 4); idle(2);
        expect_word("sub_ovf", 16'h7FFF, 1, 1);
        send_word(16'hFFFF, 16'h0001, 0, 0, 4); idle(2);
        expect_word("wrap", 16'h0000, 1, 0);
        send_word(16'h7FFF, 16'h0001, 0, 0, 4); idle(2);
        expect_word("add_ovf", 16'h8000, 0, 1);

        send_word(16'h1234, 16'h0FFF, 0, 3, 4); idle(2);
        expect_word("gaps", 16'h2233, 0, 0);

        max_run = 0;
        send_word(16'h1111, 16'h2222, 0, 0, 4);
        send_word(16'h1234, 16'h0FFF, 0, 0, 4); idle(2);
        chk("b2b_run", max_run, 8);
        expect_word("b2b_w0", 16'h3333, 0, 0);
        expect_word("b2b_w1", 16'h2233, 0, 0);

        e0 = err_cnt;
        send_word(16'hABCD, 16'h1111, 1, 0, 2);
        send_word(16'h1111, 16'h2222, 0, 0, 4); idle(2);
        chk("abort_err", err_cnt - e0, 1);
        expect_word("abort_next", 16'h3333, 0, 0);

        e0 = err_cnt;
        v0 = val_cnt;
        cyc(1, 0, 0, 4'h5, 4'h5); idle(2);
        chk("stray_err", err_cnt - e0, 1);
        chk("stray_valid", val_cnt - v0, 0);

        send_word(16'h0FFF, 16'h0FFF, 0, 0, 2);
        @(negedge clk);
        rst = 1'b0;
        valid_in = 1'b0;
        #1;
        chk("async_rst_valid", valid_out, 0);
        chk("async_rst_sum", sum, 0);
        @(negedge clk);
        rst = 1'b1;
        e0 = err_cnt;
        cyc(1, 0, 0, 4'h1, 4'h1); idle(1);
        chk("post_rst_needs_first", err_cnt - e0, 1);
        send_word(16'h0001, 16'h0001, 0, 0, 4); idle(2);
        expect_word("post_rst", 16'h0002, 0, 0);
        chk("no_extra_words", wq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
